voq_req_gen: RTL and testbench

VOQ_REQ_GEN -- requirements
Module: voq_req_gen

---
 rtl/voq_req_gen_if.sv | 35 +++
 rtl/voq_req_gen.sv | 127 ++++++++++++
 tb/tb_voq_req_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/voq_req_gen_if.sv
// Bundle of the enqueue, request and dequeue signals of voq_req_gen.
// master = upstream source plus downstream arbiter; slave = the VOQ block.
interface voq_req_gen_if #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 16,
  parameter int unsigned W = 8
);
  localparam int unsigned C  = $clog2(P);
  localparam int unsigned NW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_dest;
  logic [C-1:0]  in_pri;
  logic [W-1:0]  in_data;
  logic [N-1:0]  req;
  logic [C-1:0]  pri_req [N];
  logic [N-1:0]  accept;
  logic          deq_valid;
  logic [NW-1:0] deq_dest;
  logic [C-1:0]  deq_pri;
  logic [W-1:0]  deq_data;
  logic [N-1:0]  full;
  logic          err;

  modport master (
    output in_valid, in_dest, in_pri, in_data, accept,
    input  in_ready, req, pri_req, deq_valid, deq_dest, deq_pri, deq_data, full, err
  );

  modport slave (
    input  in_valid, in_dest, in_pri, in_data, accept,
    output in_ready, req, pri_req, deq_valid, deq_dest, deq_pri, deq_data, full, err
  );
endinterface

// File: rtl/voq_req_gen.sv
// Virtual output queues: one FIFO of {pri, data} cells per output, advertising
// non-empty status and head-cell priority to a downstream arbiter, and popping
// the head of the VOQ named by a one-hot accept.
module voq_req_gen #(
  parameter int unsigned N = 4,
  parameter int unsigned P = 16,
  parameter int unsigned D = 4,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  voq_req_gen_if.slave bus
);
  localparam int unsigned C  = $clog2(P);
  localparam int unsigned NW = $clog2(N);
  localparam int unsigned DW = $clog2(D);
  localparam int unsigned CW = $clog2(D + 1);

  logic [C-1:0]  r_pri_mem  [N][D];
  logic [W-1:0]  r_data_mem [N][D];
  logic [DW-1:0] r_rd_ptr   [N];
  logic [DW-1:0] r_wr_ptr   [N];
  logic [CW-1:0] r_count    [N];

  logic          r_deq_valid;
  logic [NW-1:0] r_deq_dest;
  logic [C-1:0]  r_deq_pri;
  logic [W-1:0]  r_deq_data;
  logic          r_err;

  logic [N-1:0]  w_req;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_push;
  logic [N-1:0]  w_pop;
  logic          w_in_ready;
  logic          w_enq;
  logic [NW-1:0] w_acc_idx;
  logic          w_acc_onehot;
  logic          w_deq;
  logic          w_acc_err;

  // Per-VOQ status decoded from the registered counts and head entries
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_req[i]       = (r_count[i] != '0);
      w_full[i]      = (r_count[i] == CW'(D));
      bus.pri_req[i] = w_req[i] ? r_pri_mem[i][r_rd_ptr[i]] : '0;
    end
  end

  assign w_in_ready = ~w_full[bus.in_dest];
  assign w_enq      = bus.in_valid & w_in_ready;

  // Accept decode: only a one-hot accept aimed at a non-empty VOQ pops
  always_comb begin
    w_acc_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.accept[i]) w_acc_idx = NW'(i);
    end
    w_acc_onehot = (bus.accept != '0) && ((bus.accept & (bus.accept - N'(1))) == '0);
    w_deq        = w_acc_onehot && w_req[w_acc_idx];
    w_acc_err    = (bus.accept != '0) && !w_deq;
  end

  // Per-VOQ push/pop strobes
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_push[i] = w_enq && (bus.in_dest == NW'(i));
      w_pop[i]  = w_deq && (w_acc_idx == NW'(i));
    end
  end

  // Pointers and counts; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end else begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + DW'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + DW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Cell storage; contents are only visible through valid pointers, so no reset
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_pri_mem[bus.in_dest][r_wr_ptr[bus.in_dest]]  <= bus.in_pri;
      r_data_mem[bus.in_dest][r_wr_ptr[bus.in_dest]] <= bus.in_data;
    end
  end

  // Dequeue result registers and sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deq_valid <= 1'b0;
      r_deq_dest  <= '0;
      r_deq_pri   <= '0;
      r_deq_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_deq_valid <= w_deq;
      if (w_deq) begin
        r_deq_dest <= w_acc_idx;
        r_deq_pri  <= r_pri_mem[w_acc_idx][r_rd_ptr[w_acc_idx]];
        r_deq_data <= r_data_mem[w_acc_idx][r_rd_ptr[w_acc_idx]];
      end
      if (w_acc_err) r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.req       = w_req;
  assign bus.full      = w_full;
  assign bus.deq_valid = r_deq_valid;
  assign bus.deq_dest  = r_deq_dest;
  assign bus.deq_pri   = r_deq_pri;
  assign bus.deq_data  = r_deq_data;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_voq_req_gen.sv
// Bench for voq_req_gen: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based model of the VOQs.
module tb_voq_req_gen;
  localparam int unsigned N = 4;
  localparam int unsigned P = 16;
  localparam int unsigned D = 4;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [3:0] pri;
    logic [7:0] data;
  } cell_t;

  typedef struct {
    logic       rst;
    logic       v;
    logic [1:0] dest;
    logic [3:0] pri;
    logic [7:0] data;
    logic [3:0] acc;
    logic [3:0] e_req;
    logic       e_dv;
    logic [1:0] e_dd;
    logic [3:0] e_dp;
    logic [7:0] e_ddat;
    logic       e_err;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  cell_t      mq [N][$];
  logic       m_err;
  logic       m_dv;
  logic [1:0] m_dd;
  logic [3:0] m_dp;
  logic [7:0] m_ddat;

  voq_req_gen_if #(.N(N), .P(P), .W(W)) bus ();

  voq_req_gen #(.N(N), .P(P), .D(D), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every registered-state output against the model
  task automatic check_outputs();
    logic [3:0] er;
    logic [3:0] ef;
    for (int i = 0; i < N; i++) begin
      er[i] = (mq[i].size() != 0);
      ef[i] = (mq[i].size() == D);
      chk($sformatf("pri_req[%0d]", i), 32'(bus.pri_req[i]),
          (mq[i].size() != 0) ? 32'(mq[i][0].pri) : 32'd0);
    end
    chk("req", 32'(bus.req), 32'(er));
    chk("full", 32'(bus.full), 32'(ef));
    chk("deq_valid", 32'(bus.deq_valid), 32'(m_dv));
    chk("deq_dest", 32'(bus.deq_dest), 32'(m_dd));
    chk("deq_pri", 32'(bus.deq_pri), 32'(m_dp));
    chk("deq_data", 32'(bus.deq_data), 32'(m_ddat));
    chk("err", 32'(bus.err), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge
  task automatic cycle(input logic rst, input logic v, input logic [1:0] dest,
                       input logic [3:0] pri, input logic [7:0] data, input logic [3:0] acc);
    int    ai;
    bit    legal;
    bit    en;
    cell_t c;
    reset        = rst;
    bus.in_valid = v;
    bus.in_dest  = dest;
    bus.in_pri   = pri;
    bus.in_data  = data;
    bus.accept   = acc;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(mq[dest].size() < D));
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_err = 1'b0; m_dv = 1'b0; m_dd = '0; m_dp = '0; m_ddat = '0;
    end else begin
      en    = v && (mq[dest].size() < D);
      ai    = 0;
      for (int i = 0; i < N; i++) if (acc[i]) ai = i;
      legal = ($countones(acc) == 1) && (mq[ai].size() != 0);
      m_dv  = 1'b0;
      if (acc != 4'd0 && !legal) m_err = 1'b1;
      if (legal) begin
        c      = mq[ai].pop_front();
        m_dv   = 1'b1;
        m_dd   = 2'(ai);
        m_dp   = c.pri;
        m_ddat = c.data;
      end
      if (en) begin
        c.pri  = pri;
        c.data = data;
        mq[dest].push_back(c);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0);
  endtask

  vec_t vec [11];

  initial begin
    int exp_p [4];
    n_tests = 0;
    n_fail  = 0;
    m_err = 1'b0; m_dv = 1'b0; m_dd = '0; m_dp = '0; m_ddat = '0;

    //          rst v  dest pri  data   acc      e_req    dv dd dp   ddat   err
    vec[0]  = '{1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 2'd2, 4'd5, 8'hA1, 4'b0000, 4'b0100, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0100, 4'b0000, 1'b1, 2'd2, 4'd5, 8'hA1, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'd5, 8'hA1, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0011, 4'b0000, 1'b0, 2'd2, 4'd5, 8'hA1, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0100, 4'b0000, 1'b0, 2'd2, 4'd5, 8'hA1, 1'b1};
    vec[6]  = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'd5, 8'hA1, 1'b1};
    vec[7]  = '{1'b1, 1'b1, 2'd1, 4'd2, 8'h55, 4'b0001, 4'b0000, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 2'd3, 4'd4, 8'h33, 4'b0000, 4'b1000, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 2'd3, 4'd9, 8'h44, 4'b1000, 4'b1000, 1'b1, 2'd3, 4'd4, 8'h33, 1'b0};
    vec[10] = '{1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 4'b1000, 4'b0000, 1'b1, 2'd3, 4'd9, 8'h44, 1'b0};

    for (int k = 0; k < 11; k++) begin
      cycle(vec[k].rst, vec[k].v, vec[k].dest, vec[k].pri, vec[k].data, vec[k].acc);
      chk($sformatf("vec%0d req", k), 32'(bus.req), 32'(vec[k].e_req));
      chk($sformatf("vec%0d deq_valid", k), 32'(bus.deq_valid), 32'(vec[k].e_dv));
      chk($sformatf("vec%0d deq_dest", k), 32'(bus.deq_dest), 32'(vec[k].e_dd));
      chk($sformatf("vec%0d deq_pri", k), 32'(bus.deq_pri), 32'(vec[k].e_dp));
      chk($sformatf("vec%0d deq_data", k), 32'(bus.deq_data), 32'(vec[k].e_ddat));
      chk($sformatf("vec%0d err", k), 32'(bus.err), 32'(vec[k].e_err));
    end

    // Fill VOQ 1, refuse a fifth cell, drain in FIFO order regardless of priority
    do_reset();
    exp_p = '{3, 9, 1, 7};
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'd1, 4'(exp_p[k]), 8'(8'h10 + k), 4'd0);
    chk("fill full[1]", 32'(bus.full[1]), 32'd1);
    chk("fill pri_req[1]", 32'(bus.pri_req[1]), 32'd3);
    cycle(1'b0, 1'b1, 2'd1, 4'd15, 8'hEE, 4'd0);
    chk("fifth not taken full[1]", 32'(bus.full[1]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 2'd1, 4'd0, 8'd0, 4'b0010);
      chk($sformatf("drain%0d deq_pri", k), 32'(bus.deq_pri), 32'(exp_p[k]));
      chk($sformatf("drain%0d deq_data", k), 32'(bus.deq_data), 32'(8'h10 + k));
      chk($sformatf("drain%0d pri_req[1]", k), 32'(bus.pri_req[1]), (k < 3) ? 32'(exp_p[k+1]) : 32'd0);
    end
    chk("drained req[1]", 32'(bus.req[1]), 32'd0);

    // Full VOQ 0: refused enqueue with a pop in the same cycle, then refill
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'd0, 4'(k + 2), 8'(8'h20 + k), 4'd0);
    cycle(1'b0, 1'b1, 2'd0, 4'd12, 8'hC0, 4'b0001);
    chk("full pop only full[0]", 32'(bus.full[0]), 32'd0);
    chk("full pop deq_data", 32'(bus.deq_data), 32'h20);
    cycle(1'b0, 1'b1, 2'd0, 4'd12, 8'hC0, 4'd0);
    chk("refill full[0]", 32'(bus.full[0]), 32'd1);

    // Wrap-around: one cell resident, ten simultaneous push/pop pairs on VOQ 0
    do_reset();
    cycle(1'b0, 1'b1, 2'd0, 4'd1, 8'h80, 4'd0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 2'd0, 4'(k + 2), 8'(8'h81 + k), 4'b0001);
      chk($sformatf("wrap%0d deq_data", k), 32'(bus.deq_data), 32'(8'h80 + k));
      chk($sformatf("wrap%0d req[0]", k), 32'(bus.req[0]), 32'd1);
      chk($sformatf("wrap%0d full[0]", k), 32'(bus.full[0]), 32'd0);
    end
    cycle(1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 4'b0001);
    chk("wrap last deq_data", 32'(bus.deq_data), 32'h8A);
    chk("wrap empty req", 32'(bus.req), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [3:0] acc;
      int         r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      acc = 4'd0;
      else if (r < 9) acc = 4'(1 << $urandom_range(0, 3));
      else            acc = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
